// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags; x0 reads as zero and is never renamed.
// Optional same-cycle commit-to-read bypass is enabled by defining RF_COMMIT_BYPASS_EN.
module reg_rename_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned TAGW = 3,
  parameter int unsigned RIDX = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RIDX-1:0] rs1,
  input  logic [RIDX-1:0] rs2,
  input  logic            issue_valid,
  input  logic [RIDX-1:0] issue_rd,
  input  logic [TAGW-1:0] issue_tag,
  input  logic            commit,
  input  logic [RIDX-1:0] commit_rd,
  input  logic [TAGW-1:0] commit_num,
  input  logic [XLEN-1:0] commit_value,
  input  logic            flush,
  output logic [XLEN-1:0] value1_rf,
  output logic [XLEN-1:0] value2_rf,
  output logic [TAGW-1:0] query1_rf,
  output logic [TAGW-1:0] query2_rf
);

  logic [XLEN-1:0] regs      [1:NREG-1];
  logic [TAGW-1:0] tags      [1:NREG-1];
  logic [TAGW-1:0] tags_next [1:NREG-1];

  // Full 0..NREG-1 views so the read ports can index with rs directly; entry 0 is the hardwired x0.
  logic [XLEN-1:0] reg_view [NREG];
  logic [TAGW-1:0] tag_view [NREG];

  // Tag next-state: later assignments win, giving flush > rename > matching commit clear.
  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      tags_next[i] = tags[i];
      if (commit && commit_rd == RIDX'(i) && tags[i] == commit_num)
        tags_next[i] = '0;
      if (issue_valid && issue_rd == RIDX'(i))
        tags_next[i] = issue_tag;
      if (flush)
        tags_next[i] = '0;
    end
  end

  // NOTE: the register array is reset here because architectural state must read zero after reset;
  // storage that is only ever read after being written would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        tags[i] <= tags_next[i];
        if (commit && commit_rd == RIDX'(i))
          regs[i] <= commit_value;
      end
    end
  end

  always_comb begin
    reg_view[0] = '0;
    tag_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      reg_view[i] = regs[i];
      tag_view[i] = tags[i];
    end
  end

  // A commit resolving the tag a reader is waiting on; only meaningful for a live (nonzero) tag.
  function automatic logic bypass_hit(input logic [RIDX-1:0] rs);
    return commit && (commit_rd == rs) && (rs != '0) &&
           (tag_view[rs] != '0) && (tag_view[rs] == commit_num);
  endfunction

  always_comb begin
    value1_rf = '0;
    query1_rf = '0;
    if (!rst) begin
      if (tag_view[rs1] == '0) value1_rf = reg_view[rs1];
      else                     query1_rf = tag_view[rs1];
`ifdef RF_COMMIT_BYPASS_EN
      if (bypass_hit(rs1)) begin
        value1_rf = commit_value;
        query1_rf = '0;
      end
`endif
    end
  end

  always_comb begin
    value2_rf = '0;
    query2_rf = '0;
    if (!rst) begin
      if (tag_view[rs2] == '0) value2_rf = reg_view[rs2];
      else                     query2_rf = tag_view[rs2];
`ifdef RF_COMMIT_BYPASS_EN
      if (bypass_hit(rs2)) begin
        value2_rf = commit_value;
        query2_rf = '0;
      end
`endif
    end
  end

`ifndef RF_COMMIT_BYPASS_EN
  // Bypass helper is only referenced when the bypass is built in.
  logic unused_bypass;
  assign unused_bypass = bypass_hit(rs1) & bypass_hit(rs2);
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios, then random ROB-like traffic
// checked against an array-based reference model of the architectural/rename state.
module tb_reg_rename_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [2:0]  commit_num;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] value1_rf, value2_rf;
  logic [2:0]  query1_rf, query2_rf;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit(commit), .commit_rd(commit_rd), .commit_num(commit_num),
    .commit_value(commit_value), .flush(flush),
    .value1_rf(value1_rf), .value2_rf(value2_rf),
    .query1_rf(query1_rf), .query2_rf(query2_rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed values and pending producer tag per register.
  logic [31:0] m_regs [32];
  logic [2:0]  m_tags [32];

  typedef struct {
    logic [2:0] tag;
    logic [4:0] rd;
  } rob_entry_t;
  rob_entry_t rob_q[$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_tags[i] = '0;
    end
  endtask

  function automatic logic model_bypass(input logic [4:0] rs);
`ifdef RF_COMMIT_BYPASS_EN
    return commit && commit_rd == rs && rs != 0 && m_tags[rs] != 0 && m_tags[rs] == commit_num;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_value(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (model_bypass(rs)) return commit_value;
    return (m_tags[rs] == 0) ? m_regs[rs] : 32'd0;
  endfunction

  function automatic logic [2:0] exp_query(input logic [4:0] rs);
    if (rs == 0 || model_bypass(rs)) return 3'd0;
    return m_tags[rs];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, ".v1"}, 64'(value1_rf), 64'(exp_value(rs1)));
    check({tag, ".q1"}, 64'(query1_rf), 64'(exp_query(rs1)));
    check({tag, ".v2"}, 64'(value2_rf), 64'(exp_value(rs2)));
    check({tag, ".q2"}, 64'(query2_rf), 64'(exp_query(rs2)));
  endtask

  // Apply the clock edge's effect to the model using the inputs held across the edge.
  task automatic model_update();
    logic [2:0] old_tags [32];
    for (int i = 0; i < 32; i++) old_tags[i] = m_tags[i];
    if (commit && commit_rd != 0) begin
      m_regs[commit_rd] = commit_value;
      if (old_tags[commit_rd] == commit_num) m_tags[commit_rd] = 3'd0;
    end
    if (issue_valid && issue_rd != 0) m_tags[issue_rd] = issue_tag;
    if (flush)
      for (int i = 0; i < 32; i++) m_tags[i] = 3'd0;
  endtask

  task automatic set_idle();
    rs1 = 0; rs2 = 0;
    issue_valid = 0; issue_rd = 0; issue_tag = 0;
    commit = 0; commit_rd = 0; commit_num = 0; commit_value = 0;
    flush = 0;
  endtask

  // Called ~1 time unit after a negedge with inputs set: check, clock, update model, return at next negedge.
  task automatic tick(input string tag);
    check_reads(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    set_idle();
  endtask

  logic [2:0] next_tag;

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;

    // 1: reset state
    repeat (2) @(negedge clk);
    rs1 = 3; rs2 = 0;
    #1;
    check("rst.v1", 64'(value1_rf), 64'd0);
    check("rst.q1", 64'(query1_rf), 64'd0);
    check("rst.v2", 64'(value2_rf), 64'd0);
    check("rst.q2", 64'(query2_rf), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    set_idle();

    // 2: rename then commit
    issue_valid = 1; issue_rd = 5; issue_tag = 2; rs1 = 5;
    #1; tick("t2.issue");
    rs1 = 5;
    #1;
    check("t2.q_pending", 64'(query1_rf), 64'd2);
    check("t2.v_pending", 64'(value1_rf), 64'd0);
    tick("t2.wait");
    commit = 1; commit_rd = 5; commit_num = 2; commit_value = 32'h1234;
    #1; tick("t2.commit");
    rs1 = 5;
    #1;
    check("t2.q_done", 64'(query1_rf), 64'd0);
    check("t2.v_done", 64'(value1_rf), 64'h1234);
    tick("t2.done");

    // 3: older commit must not erase younger rename
    issue_valid = 1; issue_rd = 7; issue_tag = 1;
    #1; tick("t3.issue1");
    issue_valid = 1; issue_rd = 7; issue_tag = 3;
    #1; tick("t3.issue3");
    commit = 1; commit_rd = 7; commit_num = 1; commit_value = 32'hAA;
    #1; tick("t3.commit");
    rs1 = 7;
    #1;
    check("t3.q_young", 64'(query1_rf), 64'd3);
    tick("t3.read");

    // 4: same-cycle rename + commit on rd=4, then flush
    issue_valid = 1; issue_rd = 4; issue_tag = 6;
    commit = 1; commit_rd = 4; commit_num = m_tags[4]; commit_value = 32'd9;
    #1; tick("t4.both");
    rs1 = 4;
    #1;
    check("t4.q_rename", 64'(query1_rf), 64'd6);
    flush = 1; rs1 = 4;
    #1; tick("t4.flush");
    rs1 = 4; rs2 = 7;
    #1;
    check("t4.q_flushed", 64'(query1_rf), 64'd0);
    check("t4.v_flushed", 64'(value1_rf), 64'd9);
    check("t3.v_kept", 64'(value2_rf), 64'hAA);
    tick("t4.read");

    // 5: same-cycle commit seen by a reader
    issue_valid = 1; issue_rd = 8; issue_tag = 4;
    #1; tick("t5.issue");
    commit = 1; commit_rd = 8; commit_num = 4; commit_value = 32'h55; rs2 = 8;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    check("t5.v_bypass", 64'(value2_rf), 64'h55);
    check("t5.q_bypass", 64'(query2_rf), 64'd0);
`else
    check("t5.q_nobypass", 64'(query2_rf), 64'd4);
    check("t5.v_nobypass", 64'(value2_rf), 64'd0);
`endif
    tick("t5.commit");

    // 6: asynchronous reset with a pending tag
    issue_valid = 1; issue_rd = 9; issue_tag = 5;
    #1; tick("t6.issue");
    rs1 = 9; rs2 = 4;
    #1;
    check("t6.q_before", 64'(query1_rf), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("t6.q1_async", 64'(query1_rf), 64'd0);
    check("t6.v1_async", 64'(value1_rf), 64'd0);
    check("t6.q2_async", 64'(query2_rf), 64'd0);
    check("t6.v2_async", 64'(value2_rf), 64'd0);
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    set_idle();
    rs1 = 4;
    #1;
    check("t6.v_cleared", 64'(value1_rf), 64'd0);
    tick("t6.after");

    // Random ROB-like traffic: in-order commit, <=5 live entries, tags cycling 1..7.
    rob_q.delete();
    next_tag = 3'd1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic do_flush;
      rob_entry_t e;
      if (rob_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        e = rob_q.pop_front();
        commit = 1; commit_rd = e.rd; commit_num = e.tag; commit_value = $urandom;
      end
      if (rob_q.size() < 5 && $urandom_range(0, 3) != 0) begin
        issue_valid = 1;
        issue_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        issue_tag = next_tag;
        next_tag = (next_tag == 3'd7) ? 3'd1 : next_tag + 3'd1;
        e.tag = issue_tag; e.rd = issue_rd;
        rob_q.push_back(e);
      end
      do_flush = ($urandom_range(0, 24) == 0);
      flush = do_flush;
      case ($urandom_range(0, 3))
        0: rs1 = commit_rd;
        1: rs1 = issue_rd;
        default: rs1 = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0: rs2 = commit_rd;
        1: rs2 = issue_rd;
        default: rs2 = 5'($urandom_range(0, 31));
      endcase
      #1; tick("rand");
      if (do_flush) rob_q.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
